ami_rd_splitter: RTL and testbench

AXI4 read-command splitter on the master side, directly upstream of the AXI slave interface's AR/R channels. Accepts one user read command (start address, byte count) at a time. Issues full-width INCR AR bursts that never cross a 4KB boundary or exceed MAX_BEATS. Forwards R beats to the user stream and signals completion with accumulated response status.

---
 rtl/ami_rd_splitter.sv | 146 ++++++++++++++
 tb/tb_ami_rd_splitter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ami_rd_splitter.sv
// AXI4 read-command splitter: turns one (addr, bytes) read command into full-width
// INCR AR bursts bounded by MAX_BEATS and 4KB pages; R beats pass straight through.
module ami_rd_splitter #(
   parameter int AXI_DW    = 128,
   parameter int AXI_AW    = 32,
   parameter int AXI_IW    = 8,
   parameter int AXI_LW    = 8,
   parameter int AXI_SW    = 3,
   parameter int MAX_BEATS = 256,
   parameter int MAX_OUTS  = 4,
   parameter int CNT_W     = 24,
   parameter int AXI_BYTES = AXI_DW/8
)(
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [AXI_AW-1:0] cmd_addr,
   input  logic [CNT_W-1:0]  cmd_bytes,
   input  logic [AXI_IW-1:0] cmd_id,
   output logic [AXI_IW-1:0] ARID,
   output logic [AXI_AW-1:0] ARADDR,
   output logic [AXI_LW-1:0] ARLEN,
   output logic [AXI_SW-1:0] ARSIZE,
   output logic [1:0]        ARBURST,
   output logic              ARVALID,
   input  logic              ARREADY,
   input  logic [AXI_DW-1:0] RDATA,
   input  logic [1:0]        RRESP,
   input  logic              RLAST,
   input  logic              RVALID,
   output logic              RREADY,
   output logic [AXI_DW-1:0] usr_rdata,
   output logic              usr_rvalid,
   input  logic              usr_rready,
   output logic              usr_rlast,
   output logic              done,
   output logic              err
);

   localparam int SZ = $clog2(AXI_BYTES);
   localparam int OW = $clog2(MAX_OUTS + 1);
   // Beat arithmetic must hold a full 4KB page worth of beats as well as cmd_bytes/AXI_BYTES.
   localparam int BW = (CNT_W > 13) ? CNT_W : 13;

   typedef enum logic [2:0] {IDLE, CALC, ISSUE, DRAIN, DONE} state_t;

   state_t            state, state_nx;
   logic [AXI_AW-1:0] addr_q;
   logic [AXI_IW-1:0] id_q;
   logic [CNT_W-1:0]  rem_q;
   logic [BW-1:0]     beats_q, beats_c, rem_w, page_beats, max_w;
   logic [12:0]       page_bytes;
   logic [AXI_LW-1:0] arlen_q;
   logic [OW-1:0]     outs_q;
   logic              err_q;
   logic              accept, param_err, ar_hs, r_hs, outs_dec, last_burst;

   assign cmd_ready  = (state == IDLE);
   assign accept     = cmd_valid & cmd_ready;
   assign param_err  = (cmd_bytes == '0) | (|cmd_addr[SZ-1:0]) | (|cmd_bytes[SZ-1:0]);
   assign ar_hs      = ARVALID & ARREADY;
   assign r_hs       = RVALID & usr_rready;
   // RLAST with nothing outstanding is an unsolicited beat and must not underflow.
   assign outs_dec   = r_hs & RLAST & (outs_q != '0);
   assign last_burst = (rem_q == CNT_W'(beats_q));

   assign ARID      = id_q;
   assign ARADDR    = addr_q;
   assign ARLEN     = arlen_q;
   assign ARSIZE    = AXI_SW'(SZ);
   assign ARBURST   = 2'b01;
   assign ARVALID   = (state == ISSUE);

   assign RREADY     = usr_rready;
   assign usr_rdata  = RDATA;
   assign usr_rvalid = RVALID;
   assign usr_rlast  = RLAST & (state == DRAIN) & (outs_q == OW'(1));

   assign done = (state == DONE);
   assign err  = (state == DONE) & err_q;

   assign rem_w      = BW'(rem_q);
   assign max_w      = BW'(MAX_BEATS);
   assign page_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
   assign page_beats = BW'(page_bytes >> SZ);

   always_comb begin
      beats_c = rem_w;
      if (max_w < beats_c)      beats_c = max_w;
      if (page_beats < beats_c) beats_c = page_beats;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (accept) state_nx = param_err ? DONE : CALC;
         CALC:  if (outs_q < OW'(MAX_OUTS)) state_nx = ISSUE;
         ISSUE: if (ar_hs) state_nx = last_burst ? DRAIN : CALC;
         DRAIN: if ((outs_q == '0) || ((outs_q == OW'(1)) && outs_dec)) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) state <= IDLE;
      else          state <= state_nx;
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         addr_q  <= '0;
         id_q    <= '0;
         rem_q   <= '0;
         beats_q <= '0;
         arlen_q <= '0;
         outs_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            addr_q <= cmd_addr;
            id_q   <= cmd_id;
            rem_q  <= cmd_bytes >> SZ;
            err_q  <= param_err;
         end else if (r_hs && (RRESP != 2'b00)) begin
            err_q  <= 1'b1;
         end
         // Burst size is re-evaluated every CALC cycle and frozen for ISSUE.
         if (state == CALC) begin
            beats_q <= beats_c;
            arlen_q <= AXI_LW'(beats_c - BW'(1));
         end
         if (ar_hs) begin
            addr_q <= addr_q + (AXI_AW'(beats_q) << SZ);
            rem_q  <= rem_q - CNT_W'(beats_q);
         end
         case ({ar_hs, outs_dec})
            2'b10:   outs_q <= outs_q + OW'(1);
            2'b01:   outs_q <= outs_q - OW'(1);
            default: outs_q <= outs_q;
         endcase
      end
   end

endmodule

// File: tb/tb_ami_rd_splitter.sv
// Directed bench for ami_rd_splitter: table of commands with hand-computed AR bursts,
// plus sequences for outstanding limit, AR stall and mid-command reset.
module tb_ami_rd_splitter;
   localparam int DW = 128, AW = 32, IW = 8, LW = 8, SW = 3, CW = 24;

   logic          ACLK = 1'b0, ARESETn = 1'b0;
   logic          cmd_valid = 1'b0, cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic [CW-1:0] cmd_bytes = '0;
   logic [IW-1:0] cmd_id = '0;
   logic [IW-1:0] ARID;
   logic [AW-1:0] ARADDR;
   logic [LW-1:0] ARLEN;
   logic [SW-1:0] ARSIZE;
   logic [1:0]    ARBURST;
   logic          ARVALID, ARREADY = 1'b1;
   logic [DW-1:0] RDATA = '0;
   logic [1:0]    RRESP = 2'b00;
   logic          RLAST = 1'b0, RVALID = 1'b0, RREADY;
   logic [DW-1:0] usr_rdata;
   logic          usr_rvalid, usr_rready = 1'b1, usr_rlast, done, err;

   ami_rd_splitter #(.AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW), .AXI_SW(SW),
                     .MAX_BEATS(256), .MAX_OUTS(2), .CNT_W(CW)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_bytes(cmd_bytes), .cmd_id(cmd_id),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .usr_rdata(usr_rdata), .usr_rvalid(usr_rvalid), .usr_rready(usr_rready),
      .usr_rlast(usr_rlast), .done(done), .err(err));

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [31:0]      addr;
      logic [23:0]      bytes;
      logic [7:0]       id;
      int               bad;
      bit               bp;
      bit               exp_err;
      int               n_ar;
      logic [3:0][31:0] a;
      logic [3:0][7:0]  l;
   } vec_t;
   vec_t vecs[$];

   int n_chk = 0, n_pass = 0;
   bit hold_r = 1'b0, flush = 1'b0, bp_en = 1'b0;
   int bad_abs = -1;

   // monitor state, cumulative across the run
   logic [31:0] log_a [64];
   logic [7:0]  log_l [64];
   logic [7:0]  log_id[64];
   int n_ar = 0, r_cnt = 0, n_rlast = 0, rlast_at = -1, n_done = 0;
   int stray_err = 0, attr_bad = 0, rdata_bad = 0, rr_bad = 0;
   bit r_hs_seen = 1'b0;
   int rq[$];

   always @(negedge ACLK) begin
      r_hs_seen <= RVALID && RREADY;
      if (ARVALID && ARREADY) begin
         if (n_ar < 64) begin
            log_a[n_ar]  <= ARADDR;
            log_l[n_ar]  <= ARLEN;
            log_id[n_ar] <= ARID;
         end
         if (ARSIZE !== 3'd4 || ARBURST !== 2'b01) attr_bad <= attr_bad + 1;
         n_ar <= n_ar + 1;
         rq.push_back(int'(ARLEN) + 1);
      end
      if (RVALID && RREADY) begin
         if (usr_rdata !== {4{32'(r_cnt) ^ 32'hA5A5_0000}}) rdata_bad <= rdata_bad + 1;
         if (usr_rlast) begin
            n_rlast  <= n_rlast + 1;
            rlast_at <= r_cnt;
         end
         r_cnt <= r_cnt + 1;
      end
      if (RREADY !== usr_rready || usr_rvalid !== RVALID) rr_bad <= rr_bad + 1;
      if (done) n_done <= n_done + 1;
      if (err && !done) stray_err <= stray_err + 1;
   end

   // R slave model: replays queued bursts in AR order
   initial begin
      int left;
      left = 0;
      forever begin
         @(posedge ACLK); #1;
         if (flush) begin
            rq.delete();
            left = 0;
         end
         if (RVALID && r_hs_seen && left > 0) left--;
         if (left == 0 && !hold_r && rq.size() > 0) left = rq.pop_front();
         if (left > 0 && !hold_r && !flush) begin
            RVALID = 1'b1;
            RLAST  = (left == 1);
            RRESP  = (r_cnt == bad_abs) ? 2'b10 : 2'b00;
            RDATA  = {4{32'(r_cnt) ^ 32'hA5A5_0000}};
         end else begin
            RVALID = 1'b0;
            RLAST  = 1'b0;
            RRESP  = 2'b00;
         end
      end
   end

   initial forever begin
      @(posedge ACLK); #1;
      usr_rready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic add_vec(input logic [31:0] addr, input logic [23:0] bytes, input logic [7:0] id,
                          input int bad, input bit bp, input bit e, input int n,
                          input logic [31:0] a0, input logic [7:0] l0,
                          input logic [31:0] a1, input logic [7:0] l1,
                          input logic [31:0] a2, input logic [7:0] l2);
      vec_t v;
      v.addr = addr; v.bytes = bytes; v.id = id; v.bad = bad; v.bp = bp;
      v.exp_err = e; v.n_ar = n;
      v.a = '0; v.l = '0;
      v.a[0] = a0; v.l[0] = l0; v.a[1] = a1; v.l[1] = l1; v.a[2] = a2; v.l[2] = l2;
      vecs.push_back(v);
   endtask

   task automatic send_cmd(input logic [31:0] addr, input logic [23:0] bytes, input logic [7:0] id);
      @(posedge ACLK); #1;
      cmd_addr = addr; cmd_bytes = bytes; cmd_id = id; cmd_valid = 1'b1;
      @(posedge ACLK); #1;
      cmd_valid = 1'b0;
   endtask

   // waits for done; returns cycles from accept and err sampled with done
   task automatic wait_done(input int budget, output bit got, output int lat,
                            output int first_arv, output logic derr);
      got = 1'b0; lat = -1; first_arv = -1; derr = 1'b0;
      for (int k = 1; k <= budget && !got; k++) begin
         @(negedge ACLK);
         if (ARVALID && first_arv < 0) first_arv = k;
         if (done) begin
            got = 1'b1; lat = k; derr = err;
         end
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int ar0, rc0, rl0, dn0, lat, farv, beats;
      bit got;
      logic derr;
      ar0 = n_ar; rc0 = r_cnt; rl0 = n_rlast; dn0 = n_done;
      bp_en = v.bp;
      bad_abs = (v.bad < 0) ? -1 : rc0 + v.bad;
      send_cmd(v.addr, v.bytes, v.id);
      wait_done(4000, got, lat, farv, derr);
      chk({tag, " done seen"}, 64'(got), 64'd1);
      repeat (3) @(negedge ACLK);
      #1;
      bp_en = 1'b0;
      if (v.n_ar == 0) chk({tag, " perr done latency"}, 64'(lat), 64'd1);
      else             chk({tag, " first ARVALID latency"}, 64'(farv), 64'd2);
      chk({tag, " err"}, 64'(derr), 64'(v.exp_err));
      chk({tag, " AR count"}, 64'(n_ar - ar0), 64'(v.n_ar));
      for (int i = 0; i < v.n_ar && i < 4; i++) begin
         chk($sformatf("%s AR%0d addr", tag, i), 64'(log_a[ar0+i]), 64'(v.a[i]));
         chk($sformatf("%s AR%0d len", tag, i), 64'(log_l[ar0+i]), 64'(v.l[i]));
         chk($sformatf("%s AR%0d id", tag, i), 64'(log_id[ar0+i]), 64'(v.id));
      end
      beats = (v.n_ar > 0) ? int'(v.bytes >> 4) : 0;
      chk({tag, " beats"}, 64'(r_cnt - rc0), 64'(beats));
      chk({tag, " rlast count"}, 64'(n_rlast - rl0), (v.n_ar > 0) ? 64'd1 : 64'd0);
      if (v.n_ar > 0) chk({tag, " rlast position"}, 64'(rlast_at), 64'(rc0 + beats - 1));
      chk({tag, " done pulses"}, 64'(n_done - dn0), 64'd1);
      bad_abs = -1;
   endtask

   initial begin
      int ar0, rc0, dn0, lat, farv;
      bit got, early, seen_rl;
      logic derr;

      #12;
      chk("reset cmd_ready", 64'(cmd_ready), 64'd1);
      chk("reset ARVALID", 64'(ARVALID), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset err", 64'(err), 64'd0);
      chk("reset ARADDR", 64'(ARADDR), 64'd0);
      chk("reset ARLEN", 64'(ARLEN), 64'd0);
      chk("reset ARID", 64'(ARID), 64'd0);
      chk("ARSIZE const", 64'(ARSIZE), 64'd4);
      chk("ARBURST const", 64'(ARBURST), 64'd1);
      @(posedge ACLK); #1;
      ARESETn = 1'b1;

      //      addr          bytes      id     bad bp err n   a0            l0   a1            l1   a2            l2
      add_vec(32'h0000_0000, 24'h100,  8'h11, -1, 0, 0, 1, 32'h0000_0000, 15,  32'h0,         0,   32'h0,         0);
      add_vec(32'h0000_0FC0, 24'h80,   8'h22, -1, 0, 0, 2, 32'h0000_0FC0, 3,   32'h0000_1000, 3,   32'h0,         0);
      add_vec(32'h0000_0000, 24'h2000, 8'h33, -1, 0, 0, 2, 32'h0000_0000, 255, 32'h0000_1000, 255, 32'h0,         0);
      add_vec(32'h0000_0100, 24'h40,   8'h44,  2, 0, 1, 1, 32'h0000_0100, 3,   32'h0,         0,   32'h0,         0);
      add_vec(32'h0000_0000, 24'h18,   8'h55, -1, 0, 1, 0, 32'h0,         0,   32'h0,         0,   32'h0,         0);
      add_vec(32'h0000_0004, 24'h40,   8'h66, -1, 0, 1, 0, 32'h0,         0,   32'h0,         0,   32'h0,         0);
      add_vec(32'h0000_0000, 24'h0,    8'h77, -1, 0, 1, 0, 32'h0,         0,   32'h0,         0,   32'h0,         0);
      add_vec(32'h0000_0F00, 24'h1200, 8'h88, -1, 1, 0, 3, 32'h0000_0F00, 15,  32'h0000_1000, 255, 32'h0000_2000, 15);

      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      // outstanding limit: R withheld, only two bursts may be issued
      ar0 = n_ar; rc0 = r_cnt; dn0 = n_done;
      hold_r = 1'b1;
      send_cmd(32'h0, 24'h4000, 8'h5A);
      repeat (40) @(negedge ACLK);
      #1;
      chk("maxouts AR count held", 64'(n_ar - ar0), 64'd2);
      chk("maxouts ARVALID low", 64'(ARVALID), 64'd0);
      hold_r = 1'b0;
      early = 1'b0; seen_rl = 1'b0; got = 1'b0; derr = 1'b0;
      for (int k = 0; k < 4000 && !got; k++) begin
         @(negedge ACLK);
         if (ARVALID && !seen_rl) early = 1'b1;
         if (RVALID && RREADY && RLAST) seen_rl = 1'b1;
         if (done) begin
            got = 1'b1; derr = err;
         end
      end
      repeat (3) @(negedge ACLK);
      #1;
      chk("maxouts done seen", 64'(got), 64'd1);
      chk("maxouts ARVALID before RLAST", 64'(early), 64'd0);
      chk("maxouts err", 64'(derr), 64'd0);
      chk("maxouts AR count", 64'(n_ar - ar0), 64'd4);
      chk("maxouts AR3 addr", 64'(log_a[ar0+3]), 64'h3000);
      chk("maxouts beats", 64'(r_cnt - rc0), 64'd1024);

      // AR stall: address and length must hold while ARREADY is low
      ar0 = n_ar; rc0 = r_cnt;
      ARREADY = 1'b0;
      send_cmd(32'h40, 24'h40, 8'h03);
      for (int k = 0; k < 10 && !ARVALID; k++) @(negedge ACLK);
      for (int k = 0; k < 5; k++) begin
         @(negedge ACLK);
         chk("stall ARVALID", 64'(ARVALID), 64'd1);
         chk("stall ARADDR", 64'(ARADDR), 64'h40);
         chk("stall ARLEN", 64'(ARLEN), 64'd3);
      end
      @(posedge ACLK); #1;
      ARREADY = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge ACLK);
         if (done) begin
            got = 1'b1; derr = err;
         end
      end
      repeat (3) @(negedge ACLK);
      #1;
      chk("stall done seen", 64'(got), 64'd1);
      chk("stall err", 64'(derr), 64'd0);
      chk("stall AR count", 64'(n_ar - ar0), 64'd1);
      chk("stall beats", 64'(r_cnt - rc0), 64'd4);

      // reset during ISSUE abandons the command silently
      ARREADY = 1'b0;
      send_cmd(32'h0, 24'h100, 8'h07);
      wait_done(2, got, lat, farv, derr);
      chk("rst ARVALID before reset", 64'(ARVALID), 64'd1);
      #2 ARESETn = 1'b0;
      #1;
      chk("rst ARVALID async", 64'(ARVALID), 64'd0);
      chk("rst cmd_ready async", 64'(cmd_ready), 64'd1);
      flush = 1'b1;
      repeat (2) @(posedge ACLK);
      #1;
      ARESETn = 1'b1;
      flush = 1'b0;
      dn0 = n_done;
      repeat (5) @(negedge ACLK);
      #1;
      chk("rst no done", 64'(n_done - dn0), 64'd0);
      chk("rst cmd_ready after", 64'(cmd_ready), 64'd1);
      chk("rst ARVALID after", 64'(ARVALID), 64'd0);
      ARREADY = 1'b1;
      run_vec(vecs[0], "post-reset");

      chk("AR attributes", 64'(attr_bad), 64'd0);
      chk("R data passthrough", 64'(rdata_bad), 64'd0);
      chk("R handshake passthrough", 64'(rr_bad), 64'd0);
      chk("err without done", 64'(stray_err), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
